// File: rtl/counter_seq_fsm.sv
// Tick-paced run sequencer: a go edge arms a run that counts up, down or
// up-then-down (bounce) one step per tick, then shows DONE for a few ticks.
module counter_seq_fsm #(
  parameter int WIDTH      = 4,
  parameter int MAX_COUNT  = 15,
  parameter int TICK_DIV   = 1500000,
  parameter int DONE_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DONE_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [WIDTH-1:0]  MAX_C     = WIDTH'(MAX_COUNT);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [DONE_W-1:0] done_cnt_q, done_cnt_d;
  logic [1:0]        mode_r_q, mode_r_d;
  logic              go_q;
  logic              pending_q, pending_d;
  logic              dir_q, dir_d;
  logic              tick;
  logic              go_rise;

  function automatic logic [WIDTH-1:0] start_val(input logic [1:0] m);
    return (m == 2'd1) ? MAX_C : '0;
  endfunction

  assign tick    = (div_q == DIV_LAST);
  assign go_rise = go & ~go_q;
  assign div_d   = tick ? '0 : div_q + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      count_q    <= '0;
      done_cnt_q <= '0;
      mode_r_q   <= 2'd0;
      go_q       <= 1'b0;
      pending_q  <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
      mode_r_q   <= mode_r_d;
      go_q       <= go;
      pending_q  <= pending_d;
      dir_q      <= dir_d;
    end
  end

  // Next-state logic; abort outranks every tick-driven transition
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_cnt_d = done_cnt_q;
    mode_r_d   = mode_r_q;
    pending_d  = pending_q;
    dir_d      = dir_q;
    if (abort) begin
      state_d    = S_IDLE;
      pending_d  = 1'b0;
      count_d    = start_val(mode);
      dir_d      = 1'b0;
      done_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_d = start_val(mode);
          if (tick && pending_q) begin
            pending_d = 1'b0;
            mode_r_d  = mode;
            dir_d     = 1'b0;
            state_d   = S_COUNT;
          end else if (go_rise) begin
            pending_d = 1'b1;
          end
        end
        S_COUNT: begin
          if (tick) begin
            case (mode_r_q)
              2'd1: begin
                if (count_q == '0) begin
                  state_d    = S_DONE;
                  done_cnt_d = '0;
                end else begin
                  count_d = count_q - 1'b1;
                end
              end
              2'd2: begin
                // Turnaround at the top consumes one tick and steps down immediately
                if (!dir_q) begin
                  if (count_q == MAX_C) begin
                    dir_d   = 1'b1;
                    count_d = count_q - 1'b1;
                  end else begin
                    count_d = count_q + 1'b1;
                  end
                end else if (count_q == '0) begin
                  state_d    = S_DONE;
                  done_cnt_d = '0;
                end else begin
                  count_d = count_q - 1'b1;
                end
              end
              default: begin
                if (count_q == MAX_C) begin
                  state_d    = S_DONE;
                  done_cnt_d = '0;
                end else begin
                  count_d = count_q + 1'b1;
                end
              end
            endcase
          end
        end
        S_DONE: begin
          if (tick) begin
            if (done_cnt_q == DONE_LAST) begin
              state_d = S_IDLE;
              count_d = start_val(mode);
            end else begin
              done_cnt_d = done_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
          count_d   = start_val(mode);
          dir_d     = 1'b0;
        end
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    busy  = (state_q == S_COUNT);
    done  = (state_q == S_DONE);
    count = count_q;
  end

endmodule

// File: tb/tb_counter_seq_fsm.sv
// Self-checking bench: directed scenarios plus random go/abort/mode traffic,
// compared every clock against a run-schedule reference model.
module tb_counter_seq_fsm;
  localparam int WIDTH      = 4;
  localparam int MAX_COUNT  = 15;
  localparam int TICK_DIV   = 4;
  localparam int DONE_TICKS = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             abort;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  counter_seq_fsm #(
    .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .TICK_DIV(TICK_DIV), .DONE_TICKS(DONE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .mode(mode),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 running, 2 done; a run is a queue of counts
  int m_phase, m_count, m_cyc, m_done_left;
  bit m_pending, m_go_prev;
  int m_seq[$];

  int busy_cycles, done_cycles, done_pulses;
  bit prev_done_obs;

  function automatic int start_of(input int md);
    return (md == 1) ? MAX_COUNT : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_cyc = 0; m_done_left = 0;
    m_pending = 0; m_go_prev = 0;
    m_seq.delete();
  endtask

  task automatic build_run(input int md);
    m_seq.delete();
    if (md == 1) begin
      m_count = MAX_COUNT;
      for (int v = MAX_COUNT - 1; v >= 0; v--) m_seq.push_back(v);
    end else if (md == 2) begin
      m_count = 0;
      for (int v = 1; v <= MAX_COUNT; v++) m_seq.push_back(v);
      for (int v = MAX_COUNT - 1; v >= 0; v--) m_seq.push_back(v);
    end else begin
      m_count = 0;
      for (int v = 1; v <= MAX_COUNT; v++) m_seq.push_back(v);
    end
  endtask

  task automatic model_edge();
    bit tick;
    bit rise;
    if (rst) begin
      model_reset();
      return;
    end
    tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    rise = go && !m_go_prev;
    if (abort) begin
      m_phase = 0; m_pending = 0; m_count = start_of(int'(mode));
    end else if (m_phase == 0) begin
      if (tick && m_pending) begin
        m_pending = 0;
        build_run(int'(mode));
        m_phase = 1;
      end else begin
        if (rise) m_pending = 1;
        m_count = start_of(int'(mode));
      end
    end else if (m_phase == 1) begin
      if (tick) begin
        if (m_seq.size() == 0) begin
          m_phase = 2; m_done_left = DONE_TICKS;
        end else begin
          m_count = m_seq.pop_front();
        end
      end
    end else begin
      if (tick) begin
        m_done_left--;
        if (m_done_left == 0) begin
          m_phase = 0; m_count = start_of(int'(mode));
        end
      end
    end
    m_go_prev = go;
    m_cyc++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    busy_cycles += int'(busy);
    done_cycles += int'(done);
    if (done && !prev_done_obs) done_pulses++;
    prev_done_obs = done;
  endtask

  task automatic clear_tally();
    busy_cycles = 0; done_cycles = 0; done_pulses = 0;
  endtask

  task automatic go_pulse();
    go = 1'b1; cycle(); go = 1'b0;
  endtask

  task automatic run_to_idle(input int limit);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (m_phase != 0 && n < limit);
    chk("idle_reached", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; mode = 2'd0;
    prev_done_obs = 0;
    model_reset();
    clear_tally();
    repeat (3) cycle();
    chk("reset_count", 32'(count), 32'd0);
    rst = 1'b0;
    $display("reset released at t=%0t", $time);

    // Up run
    repeat (2) cycle();
    clear_tally();
    go_pulse();
    run_to_idle(300);
    chk("up_busy_clks", busy_cycles, 64);
    chk("up_done_clks", done_cycles, 4);
    chk("up_done_pulses", done_pulses, 1);
    chk("up_end_count", 32'(count), 32'd0);
    $display("up run: busy=%0d done=%0d clks", busy_cycles, done_cycles);

    // Down run
    mode = 2'd1;
    repeat (2) cycle();
    chk("down_idle_count", 32'(count), 32'd15);
    clear_tally();
    go_pulse();
    run_to_idle(300);
    chk("down_busy_clks", busy_cycles, 64);
    chk("down_done_clks", done_cycles, 4);
    chk("down_end_count", 32'(count), 32'd15);
    $display("down run: busy=%0d done=%0d clks", busy_cycles, done_cycles);

    // Bounce run, mode input changed mid-run must not matter
    mode = 2'd2;
    repeat (2) cycle();
    clear_tally();
    go_pulse();
    repeat (20) cycle();
    mode = 2'd1;
    run_to_idle(400);
    chk("bounce_busy_clks", busy_cycles, 124);
    chk("bounce_done_clks", done_cycles, 4);
    chk("bounce_end_count", 32'(count), 32'd15);
    $display("bounce run: busy=%0d done=%0d clks", busy_cycles, done_cycles);

    // Abort at count 7 coincident with a tick
    mode = 2'd0;
    repeat (2) cycle();
    go_pulse();
    begin
      int n = 0;
      while (!(m_phase == 1 && m_count == 7 && (m_cyc % TICK_DIV) == TICK_DIV - 1) && n < 300) begin
        cycle(); n++;
      end
      chk("abort_setup_busy", 32'(busy), 32'd1);
    end
    clear_tally();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (40) cycle();
    chk("abort_no_done", done_cycles, 0);
    $display("abort: done clks after abort=%0d", done_cycles);

    // go held high: exactly one run
    clear_tally();
    go = 1'b1;
    repeat (250) cycle();
    go = 1'b0;
    chk("go_held_runs", done_pulses, 1);
    $display("go held: runs=%0d", done_pulses);

    // Second go edge during COUNT is ignored
    repeat (4) cycle();
    clear_tally();
    go_pulse();
    repeat (20) cycle();
    go_pulse();
    repeat (200) cycle();
    chk("second_go_runs", done_pulses, 1);
    $display("second go edge: runs=%0d", done_pulses);

    // Asynchronous reset mid-run at count 9
    go_pulse();
    begin
      int n = 0;
      while (!(m_phase == 1 && m_count == 9) && n < 300) begin
        cycle(); n++;
      end
      chk("rst_setup_count", 32'(count), 32'd9);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_async_count", 32'(count), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    model_reset();
    clear_tally();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (100) cycle();
    chk("rst_no_run_busy", busy_cycles, 0);
    chk("rst_no_run_done", done_pulses, 0);
    $display("mid-run reset: busy clks after release=%0d", busy_cycles);

    // Random traffic
    clear_tally();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) go = ~go;
      abort = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      cycle();
    end
    go = 1'b0; abort = 1'b0;
    run_to_idle(400);
    $display("random traffic: runs=%0d", done_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
